rotate_sdram_port: RTL and testbench
====================================

ROTATE_SDRAM_PORT -- requirements
Module: rotate_sdram_port

Interface
REQ-001 Parameters: ADDR_WIDTH, default 21, memory word-address width; RD_BURST, default 8, read burst length in words; WR_BURST, default 16, write burst length in words.
REQ-002 clk_sys  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 vidin_req  input  1  write burst pending; vidin_frame input 1; vidin_row input 10; vidin_col input 10; vidin_d input 16.
REQ-005 vidin_ack  output  1  one-cycle pulse; the current write word has been consumed.
REQ-006 vidout_req  input  1  row fetch active; vidout_frame input 1; vidout_row input 10 (source x); vidout_col input 10 (source y).
REQ-007 vidout_d  output  16  read data; vidout_ack output 1, one-cycle pulse marking vidout_d valid.
REQ-008 mem_req  output  1  memory request; mem_we output 1; mem_addr output ADDR_WIDTH; mem_d output 16.
REQ-009 mem_ack  input  1  per-word strobe: write accepted, or read word valid on mem_q; mem_q input 16.

Function
REQ-010 Cornerturn addressing SHALL be: write address = {vidin_frame, vidin_col, vidin_row}; read address = {vidout_frame, vidout_row, vidout_col[9:3], 3'b000}.
REQ-011 FSM states SHALL be IDLE, WR_SETTLE, WR_REQ, RD_REQ, RD_DATA.
REQ-012 IDLE: if vidin_req is high, go to WR_SETTLE; else if vidout_req is high, go to RD_REQ; else stay.
REQ-013 WR_SETTLE SHALL last exactly 2 cycles, absorbing the upstream register latency of vidin_d/vidin_col, then go to WR_REQ, latching mem_addr and mem_d.
REQ-014 WR_REQ: mem_req=1, mem_we=1. On mem_ack: pulse vidin_ack (same registered edge as mem_req falling) and increment the word counter. If the count reaches WR_BURST, go to IDLE; otherwise go to WR_SETTLE.
REQ-015 RD_REQ: mem_req=1, mem_we=0, mem_addr latched at entry; go to RD_DATA on the same cycle.
REQ-016 RD_DATA: each mem_ack SHALL produce vidout_ack=1 and vidout_d=mem_q exactly 1 cycle later; mem_req drops after the RD_BURST-th ack, then go to IDLE.
REQ-017 A read burst SHALL complete all RD_BURST words even if vidout_req falls mid-burst; surplus words are still acked.
REQ-018 mem_addr, mem_we and mem_d SHALL be stable while mem_req is high.
REQ-019 Arbitration: writes win simultaneous requests, with one exception. After a completed write burst, a pending vidout_req SHALL be served with one read burst before the next write burst.
REQ-020 mem_ack while mem_req is low SHALL be ignored.
REQ-021 Word counter is 5 bits; it SHALL clear on entry to IDLE and never wrap within a burst.

Reset
REQ-022 On reset, the block SHALL immediately enter IDLE, clear all counters and the alternation flag, and abandon any in-flight burst.
REQ-023 On reset, all outputs (mem_req, mem_we, mem_addr, mem_d, vidin_ack, vidout_ack, vidout_d) SHALL be 0.

Configuration
REQ-024 Macro ROTATE_DOUBLEBUF_EN. When defined, the frame bits are used as in REQ-010. When undefined, the address MSB SHALL be forced 0 and vidin_frame/vidout_frame ignored (single buffer).

Structure
REQ-025 Package rotate_pkg SHALL hold the FSM state enum, ADDR_WIDTH/burst defaults, and the address field offsets (Y at [9:0], X at [19:10], frame at [20]).
REQ-026 One sub-module, rotate_addr_gen, SHALL implement the combinational write/read address build of REQ-010 and REQ-024.

Verification
REQ-027 Write burst: vidin_req=1, frame=1, row=5, col base 32, mem_ack 1 cycle after each req -> 16 writes with mem_addr = 0x100000|(32+i)<<10|5, 16 vidin_ack pulses, each word latched 2 cycles after the prior ack.
REQ-028 Read burst: vidout_req=1, frame=0, row=100, col=8 -> mem_addr=100<<10|8, mem_we=0; 8 mem_ack with mem_q=i -> vidout_ack/vidout_d=i, each 1 cycle after its mem_ack.
REQ-029 Simultaneous vidin_req and vidout_req in IDLE -> write burst first; then exactly one read burst, then the next write.
REQ-030 vidout_req dropped after the 3rd read word -> all 8 words are still acked, then IDLE.
REQ-031 Reset asserted mid write burst at word 7 -> all outputs are 0 the same cycle; the next vidin_req restarts at word 0.
REQ-032 Build without ROTATE_DOUBLEBUF_EN, frame=1 -> mem_addr[20]=0 for both reads and writes.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and constants for the cornerturn SDRAM port: FSM states, burst defaults and
// the address field layout used by the address builder.
package rotate_pkg;

  localparam int unsigned DefAddrWidth = 21;
  localparam int unsigned DefRdBurst   = 8;
  localparam int unsigned DefWrBurst   = 16;

  localparam int unsigned CoordWidth = 10;
  localparam int unsigned YLsb       = 0;
  localparam int unsigned XLsb       = 10;
  localparam int unsigned FrameBit   = 20;
  // Reads fetch chunks aligned to this many low address bits.
  localparam int unsigned ChunkLsbs  = 3;

  localparam int unsigned CntWidth = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWrSettle,
    StWrReq,
    StRdReq,
    StRdData
  } state_e;

endpackage

// File: rtl/rotate_addr_gen.sv
// Combinational cornerturn address builder. The frame bit is only honoured when
// ROTATE_DOUBLEBUF_EN is defined; otherwise the block runs single-buffered.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  wr_frame_i,
  input  logic [CoordWidth-1:0] wr_row_i,
  input  logic [CoordWidth-1:0] wr_col_i,
  input  logic                  rd_frame_i,
  input  logic [CoordWidth-1:0] rd_row_i,
  input  logic [CoordWidth-1:0] rd_col_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  logic              wr_frame;
  logic              rd_frame;
  logic [FrameBit:0] wr_full;
  logic [FrameBit:0] rd_full;
  logic              unused_bits;

`ifdef ROTATE_DOUBLEBUF_EN
  assign wr_frame    = wr_frame_i;
  assign rd_frame    = rd_frame_i;
  assign unused_bits = ^rd_col_i[ChunkLsbs-1:0];
`else
  assign wr_frame    = 1'b0;
  assign rd_frame    = 1'b0;
  assign unused_bits = wr_frame_i ^ rd_frame_i ^ (^rd_col_i[ChunkLsbs-1:0]);
`endif

  // Writes store a source column contiguously; reads pull an aligned chunk of a stored row.
  always_comb begin
    wr_full                     = '0;
    wr_full[FrameBit]           = wr_frame;
    wr_full[XLsb +: CoordWidth] = wr_col_i;
    wr_full[YLsb +: CoordWidth] = wr_row_i;

    rd_full                     = '0;
    rd_full[FrameBit]           = rd_frame;
    rd_full[XLsb +: CoordWidth] = rd_row_i;
    rd_full[YLsb +: CoordWidth] = {rd_col_i[CoordWidth-1:ChunkLsbs], {ChunkLsbs{1'b0}}};
  end

  assign wr_addr_o = ADDR_WIDTH'(wr_full);
  assign rd_addr_o = ADDR_WIDTH'(rd_full);

endmodule

// File: rtl/rotate_sdram_port.sv
// Cornerturn SDRAM port: arbitrates single-word write bursts from video-in against row reads
// for video-out. Define ROTATE_DOUBLEBUF_EN to use the frame bit (double buffering).
module rotate_sdram_port
  import rotate_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RD_BURST   = DefRdBurst,
  parameter int unsigned WR_BURST   = DefWrBurst
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  vidin_req,
  input  logic                  vidin_frame,
  input  logic [9:0]            vidin_row,
  input  logic [9:0]            vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic                  vidout_frame,
  input  logic [9:0]            vidout_row,
  input  logic [9:0]            vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_d,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_q
);

  localparam logic [CntWidth-1:0] WrLast = CntWidth'(WR_BURST);
  localparam logic [CntWidth-1:0] RdLast = CntWidth'(RD_BURST);

  state_e                state_q, state_d;
  logic                  settle_q, settle_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  alt_q, alt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_d_q, mem_d_d;
  logic                  vidin_ack_q, vidin_ack_d;
  logic                  vidout_ack_q, vidout_ack_d;
  logic [15:0]           vidout_d_q, vidout_d_d;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  ack_valid;
  logic                  start_rd;
  logic [CntWidth-1:0]   cnt_inc;

  rotate_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .wr_frame_i(vidin_frame),
    .wr_row_i  (vidin_row),
    .wr_col_i  (vidin_col),
    .rd_frame_i(vidout_frame),
    .rd_row_i  (vidout_row),
    .rd_col_i  (vidout_col),
    .wr_addr_o (wr_addr),
    .rd_addr_o (rd_addr)
  );

  assign ack_valid = mem_ack & mem_req_q;
  assign cnt_inc   = cnt_q + CntWidth'(1);
  // Writes win, except that a finished write burst owes a pending reader one read burst.
  assign start_rd  = vidout_req & (alt_q | ~vidin_req);

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    alt_d        = alt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_d_d      = mem_d_q;
    vidin_ack_d  = 1'b0;
    vidout_ack_d = 1'b0;
    vidout_d_d   = vidout_d_q;

    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        settle_d = 1'b0;
        if (start_rd) begin
          state_d    = StRdReq;
          alt_d      = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr;
        end else if (vidin_req) begin
          state_d = StWrSettle;
          alt_d   = 1'b0;
        end
      end
      StWrSettle: begin
        // Two cycles let the upstream registers advance vidin_d/vidin_col after an ack.
        if (settle_q) begin
          state_d    = StWrReq;
          settle_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr;
          mem_d_d    = vidin_d;
        end else begin
          settle_d = 1'b1;
        end
      end
      StWrReq: begin
        if (ack_valid) begin
          mem_req_d   = 1'b0;
          vidin_ack_d = 1'b1;
          if (cnt_inc == WrLast) begin
            state_d  = StIdle;
            cnt_d    = '0;
            mem_we_d = 1'b0;
            alt_d    = 1'b1;
          end else begin
            state_d = StWrSettle;
            cnt_d   = cnt_inc;
          end
        end
      end
      StRdReq, StRdData: begin
        if (state_q == StRdReq) begin
          state_d = StRdData;
        end
        if (ack_valid) begin
          vidout_ack_d = 1'b1;
          vidout_d_d   = mem_q;
          cnt_d        = cnt_inc;
          if (cnt_inc == RdLast) begin
            state_d   = StIdle;
            cnt_d     = '0;
            mem_req_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      settle_q     <= 1'b0;
      cnt_q        <= '0;
      alt_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      vidin_ack_q  <= 1'b0;
      vidout_ack_q <= 1'b0;
      vidout_d_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      alt_q        <= alt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_d_q      <= mem_d_d;
      vidin_ack_q  <= vidin_ack_d;
      vidout_ack_q <= vidout_ack_d;
      vidout_d_q   <= vidout_d_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_d      = mem_d_q;
  assign vidin_ack  = vidin_ack_q;
  assign vidout_ack = vidout_ack_q;
  assign vidout_d   = vidout_d_q;

endmodule

// File: tb/tb_rotate_sdram_port.sv
// Directed bench for rotate_sdram_port: the bench plays both video sides and the memory,
// recording what it sees, and each test task compares against hand-derived values.
module tb_rotate_sdram_port;

`ifdef ROTATE_DOUBLEBUF_EN
  localparam logic Dbuf = 1'b1;
`else
  localparam logic Dbuf = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vidin_req, vidin_frame;
  logic [9:0]  vidin_row, vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req, vidout_frame;
  logic [9:0]  vidout_row, vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req, mem_we;
  logic [20:0] mem_addr;
  logic [15:0] mem_d;
  logic        mem_ack;
  logic [15:0] mem_q;

  int checks = 0;
  int errors = 0;

  logic [20:0] w_addr [32];
  logic [15:0] w_data [32];
  logic        w_we   [32];
  logic        w_pulse[32];
  int          w_wait [32];
  int          w_words, w_extra_ack, w_timeout;

  logic [20:0] r_addr, r_addr_hold;
  logic        r_we;
  int          r_wait, r_timeout;
  logic        r_vack[8];
  logic [15:0] r_vd  [8];
  logic        r_req [8];

  always #5 clk_sys = ~clk_sys;

  rotate_sdram_port dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vidin_req   (vidin_req),
    .vidin_frame (vidin_frame),
    .vidin_row   (vidin_row),
    .vidin_col   (vidin_col),
    .vidin_d     (vidin_d),
    .vidin_ack   (vidin_ack),
    .vidout_req  (vidout_req),
    .vidout_frame(vidout_frame),
    .vidout_row  (vidout_row),
    .vidout_col  (vidout_col),
    .vidout_d    (vidout_d),
    .vidout_ack  (vidout_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_d       (mem_d),
    .mem_ack     (mem_ack),
    .mem_q       (mem_q)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Write source plus memory: ack each request one cycle after it appears; the upstream
  // advances col/data on every vidin_ack pulse.
  task automatic drive_write(input logic frame, input logic [9:0] row, input logic [9:0] col0,
                             input int nwords, input logic keep_req, input logic spurious);
    int cnt;
    w_words = 0; w_extra_ack = 0; w_timeout = 0;
    vidin_frame = frame; vidin_row = row; vidin_col = col0;
    vidin_d = 16'hC000 + {6'd0, col0};
    vidin_req = 1'b1;
    for (int w = 0; w < nwords && w_timeout == 0; w++) begin
      cnt = 0;
      while (!mem_req && cnt < 10) begin
        mem_ack = spurious;
        step();
        cnt++;
        if (vidin_ack) w_extra_ack++;
      end
      mem_ack = 1'b0;
      if (!mem_req) begin
        w_timeout = 1;
      end else begin
        w_wait[w] = cnt; w_addr[w] = mem_addr; w_data[w] = mem_d; w_we[w] = mem_we;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        w_pulse[w] = vidin_ack && !mem_req;
        w_words++;
        if (vidin_ack) begin
          vidin_col = vidin_col + 10'd1;
          vidin_d   = vidin_d + 16'd1;
        end
      end
    end
    if (!keep_req) vidin_req = 1'b0;
  endtask

  // Read sink plus memory: hold the request 2 cycles with scrambled inputs, then ack every cycle.
  task automatic drive_read(input logic frame, input logic [9:0] row, input logic [9:0] col,
                            input logic [15:0] qbase, input int drop_after, input logic keep_req);
    int cnt;
    r_timeout = 0;
    vidout_frame = frame; vidout_row = row; vidout_col = col;
    vidout_req = 1'b1;
    cnt = 0;
    while (!mem_req && cnt < 10) begin
      step();
      cnt++;
    end
    r_wait = cnt;
    if (!mem_req) begin
      r_timeout = 1;
    end else begin
      r_addr = mem_addr; r_we = mem_we;
      vidout_row = ~row; vidout_col = ~col; vidout_frame = ~frame;
      step();
      step();
      r_addr_hold = mem_addr;
      for (int i = 0; i < 8; i++) begin
        mem_q = qbase + 16'(i);
        mem_ack = 1'b1;
        step();
        r_vack[i] = vidout_ack; r_vd[i] = vidout_d; r_req[i] = mem_req;
        if (i + 1 == drop_after) vidout_req = 1'b0;
      end
      mem_ack = 1'b0;
      mem_q = 16'hFFFF;
    end
    if (!keep_req) vidout_req = 1'b0;
    vidout_frame = frame; vidout_row = row; vidout_col = col;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vidin_req = 0; vidin_frame = 0; vidin_row = '0; vidin_col = '0; vidin_d = '0;
    vidout_req = 0; vidout_frame = 0; vidout_row = '0; vidout_col = '0;
    mem_ack = 0; mem_q = '0;
    step();
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 21'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_d !== 16'd0) begin errors++; $display("FAIL rst_mem_d: got %h want 0", mem_d); end
    checks++; if (vidin_ack !== 1'b0) begin errors++; $display("FAIL rst_vidin_ack: got %b want 0", vidin_ack); end
    checks++; if (vidout_ack !== 1'b0) begin errors++; $display("FAIL rst_vidout_ack: got %b want 0", vidout_ack); end
    checks++; if (vidout_d !== 16'd0) begin errors++; $display("FAIL rst_vidout_d: got %h want 0", vidout_d); end
    reset = 1'b0;
    step();
  endtask

  task automatic check_write_burst(input string tag, input logic frame, input logic [9:0] row,
                                   input logic [9:0] col0);
    logic [20:0] ea;
    logic [15:0] ed;
    checks++; if (w_timeout != 0 || w_words != 16) begin errors++;
      $display("FAIL %s words: got %0d (timeout %0d) want 16", tag, w_words, w_timeout); end
    for (int i = 0; i < w_words; i++) begin
      ea = {frame & Dbuf, col0 + 10'(i), row};
      ed = 16'hC000 + {6'd0, col0} + 16'(i);
      checks++; if (w_addr[i] !== ea) begin errors++;
        $display("FAIL %s addr[%0d]: got %h want %h", tag, i, w_addr[i], ea); end
      checks++; if (w_data[i] !== ed || w_we[i] !== 1'b1) begin errors++;
        $display("FAIL %s data[%0d]: got %h we %b want %h we 1", tag, i, w_data[i], w_we[i], ed); end
      checks++; if (w_pulse[i] !== 1'b1) begin errors++;
        $display("FAIL %s ack_pulse[%0d]: got %b want 1", tag, i, w_pulse[i]); end
      checks++; if (w_wait[i] != (i == 0 ? 3 : 2)) begin errors++;
        $display("FAIL %s latency[%0d]: got %0d want %0d", tag, i, w_wait[i], (i == 0 ? 3 : 2)); end
    end
    checks++; if (w_extra_ack != 0) begin errors++;
      $display("FAIL %s stray_vidin_ack: got %0d want 0", tag, w_extra_ack); end
  endtask

  task automatic check_idle(input string tag, input int n);
    int busy;
    busy = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (mem_req || vidin_ack || vidout_ack) busy++;
    end
    checks++; if (busy != 0) begin errors++;
      $display("FAIL %s idle: got %0d busy cycles want 0", tag, busy); end
  endtask

  task automatic check_read_burst(input string tag, input logic [20:0] ea, input logic [15:0] qb);
    checks++; if (r_timeout != 0 || r_wait != 1) begin errors++;
      $display("FAIL %s req_latency: got %0d (timeout %0d) want 1", tag, r_wait, r_timeout); end
    checks++; if (r_addr !== ea || r_we !== 1'b0) begin errors++;
      $display("FAIL %s addr: got %h we %b want %h we 0", tag, r_addr, r_we, ea); end
    checks++; if (r_addr_hold !== ea) begin errors++;
      $display("FAIL %s addr_stable: got %h want %h", tag, r_addr_hold, ea); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (r_vack[i] !== 1'b1 || r_vd[i] !== qb + 16'(i)) begin errors++;
        $display("FAIL %s word[%0d]: got ack %b d %h want ack 1 d %h", tag, i, r_vack[i],
                 r_vd[i], qb + 16'(i)); end
      checks++; if (r_req[i] !== (i < 7)) begin errors++;
        $display("FAIL %s mem_req_after[%0d]: got %b want %b", tag, i, r_req[i], (i < 7)); end
    end
  endtask

  task automatic test_write_burst();
    drive_write(1'b1, 10'd5, 10'd32, 16, 1'b0, 1'b0);
    check_write_burst("wr_burst", 1'b1, 10'd5, 10'd32);
    check_idle("wr_burst_end", 4);
  endtask

  task automatic test_read_burst();
    drive_read(1'b0, 10'd100, 10'd8, 16'h0000, 8, 1'b0);
    check_read_burst("rd_burst", 21'd102408, 16'h0000);
    check_idle("rd_burst_end", 3);
  endtask

  task automatic test_frame_mask();
    drive_read(1'b1, 10'd3, 10'd17, 16'h7700, 8, 1'b0);
    check_read_burst("rd_frame1", {Dbuf, 10'd3, 10'd16}, 16'h7700);
  endtask

  task automatic test_drop_mid_read();
    drive_read(1'b0, 10'd7, 10'd45, 16'h5500, 3, 1'b0);
    check_read_burst("rd_drop", {1'b0, 10'd7, 10'd40}, 16'h5500);
    check_idle("rd_drop_end", 4);
  endtask

  task automatic test_arbitration();
    vidout_frame = 1'b0; vidout_row = 10'd9; vidout_col = 10'd24;
    vidout_req = 1'b1;
    drive_write(1'b0, 10'd2, 10'd100, 16, 1'b1, 1'b0);
    check_write_burst("arb_wr1", 1'b0, 10'd2, 10'd100);
    drive_read(1'b0, 10'd9, 10'd24, 16'h3300, 8, 1'b1);
    check_read_burst("arb_rd1", {1'b0, 10'd9, 10'd24}, 16'h3300);
    drive_write(1'b0, 10'd2, 10'd200, 16, 1'b0, 1'b0);
    check_write_burst("arb_wr2", 1'b0, 10'd2, 10'd200);
    drive_read(1'b0, 10'd9, 10'd24, 16'h4400, 8, 1'b0);
    check_read_burst("arb_rd2", {1'b0, 10'd9, 10'd24}, 16'h4400);
  endtask

  task automatic test_reset_mid_write();
    drive_write(1'b1, 10'd12, 10'd500, 7, 1'b1, 1'b0);
    step();
    step();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++;
      $display("FAIL rst_mid_word7_req: got req %b we %b want 1 1", mem_req, mem_we); end
    reset = 1'b1;
    #1;
    checks++; if ({mem_req, mem_we, vidin_ack, vidout_ack} !== 4'b0) begin errors++;
      $display("FAIL rst_mid_ctrl: got %b want 0000", {mem_req, mem_we, vidin_ack, vidout_ack}); end
    checks++; if (mem_addr !== 21'd0 || mem_d !== 16'd0 || vidout_d !== 16'd0) begin errors++;
      $display("FAIL rst_mid_data: got addr %h d %h vd %h want 0", mem_addr, mem_d, vidout_d); end
    step();
    reset = 1'b0;
    drive_write(1'b1, 10'd12, 10'd600, 16, 1'b0, 1'b0);
    check_write_burst("rst_restart", 1'b1, 10'd12, 10'd600);
    check_idle("rst_restart_end", 4);
  endtask

  task automatic test_ignore_ack();
    int busy;
    busy = 0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_req || vidin_ack || vidout_ack) busy++;
    end
    mem_ack = 1'b0;
    checks++; if (busy != 0) begin errors++;
      $display("FAIL idle_ack_ignored: got %0d busy cycles want 0", busy); end
    drive_write(1'b0, 10'd1, 10'd0, 16, 1'b0, 1'b1);
    check_write_burst("settle_ack_ignored", 1'b0, 10'd1, 10'd0);
    check_idle("settle_ack_end", 4);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_frame_mask();
    test_drop_mid_read();
    test_arbitration();
    test_reset_mid_write();
    test_ignore_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
